// File: rtl/puf_eval_ctrl_if.sv
// ---------------------------------------------------------------------------
// puf_eval_ctrl_if
// Bundles the host handshake and datapath signals of the ring-oscillator PUF
// sequencer so they can travel as a single port.
//
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//   ena        in   design enable; low aborts any evaluation
//   start      in   begin a challenge (honoured only while idle)
//   abort      in   cancel the evaluation and return to idle
//   chal_a/b   in   base oscillator selects for bank A / bank B
//   count_a/b  in   edge counts from the two datapath counters
//   sel_a/b    out  oscillator selects driven to the datapath muxes
//   ro_en      out  oscillator enable
//   cnt_clr    out  edge counter clear
//   busy       out  sequencer is not idle
//   done       out  one-cycle pulse when a response completes
//   resp       out  response register, first evaluated bit in the MSB
//   resp_valid out  resp holds a complete response
//   tie_cnt    out  number of evaluations where the counts were equal
//
// master: host plus datapath side.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface puf_eval_ctrl_if #(
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 32,
  parameter int N_BITS = 8
);
  localparam int TIE_W = $clog2(N_BITS + 1);

  logic              ena;
  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  chal_a;
  logic [SEL_W-1:0]  chal_b;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              ro_en;
  logic              cnt_clr;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] resp;
  logic              resp_valid;
  logic [TIE_W-1:0]  tie_cnt;

  modport master (
    output ena, start, abort, chal_a, chal_b, count_a, count_b,
    input  sel_a, sel_b, ro_en, cnt_clr, busy, done, resp, resp_valid, tie_cnt
  );

  modport slave (
    input  ena, start, abort, chal_a, chal_b, count_a, count_b,
    output sel_a, sel_b, ro_en, cnt_clr, busy, done, resp, resp_valid, tie_cnt
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// puf_eval_ctrl
// Sequencer for the ring-oscillator PUF datapath. For every challenge it runs
// N_BITS evaluations; each one selects an oscillator pair, clears the edge
// counters, enables the oscillators for WINDOW cycles, lets the counts settle
// for SETTLE cycles and then compares them into one response bit, which is
// shifted into the response register.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   bus    slave side of puf_eval_ctrl_if (host handshake + datapath I/O)
// ---------------------------------------------------------------------------
module puf_eval_ctrl #(
  parameter int WINDOW = 256,
  parameter int SETTLE = 4,
  parameter int N_BITS = 8,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  puf_eval_ctrl_if.slave  bus
);

  // Bit index needs to reach N_BITS, the timer the longest dwell minus one.
  localparam int KW   = $clog2(N_BITS + 1);
  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [KW-1:0]      k_q, k_d;
  logic [SEL_W-1:0]   chalA_q, chalA_d;
  logic [SEL_W-1:0]   chalB_q, chalB_d;
  logic [N_BITS-1:0]  resp_q, resp_d;
  logic               respValid_q, respValid_d;
  logic [KW-1:0]      tieCnt_q, tieCnt_d;

  logic               kill;
  logic               timerZero;
  logic               cmpGt;
  logic               cmpEq;
  logic               selActive;
  logic [SEL_W-1:0]   kSel;

  // Abort and a dropped enable share one path back to idle.
  assign kill      = bus.abort || !bus.ena;
  assign timerZero = (timer_q == '0);
  assign cmpGt     = (bus.count_a > bus.count_b);
  assign cmpEq     = (bus.count_a == bus.count_b);

  // The bit index is added modulo 2**SEL_W so the selects wrap naturally.
  assign kSel      = SEL_W'(k_q);
  assign selActive = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                     (state_q == S_SETTLE) || (state_q == S_COMPARE);

  // Register bank; asynchronous reset so ro_en drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      k_q         <= '0;
      chalA_q     <= '0;
      chalB_q     <= '0;
      resp_q      <= '0;
      respValid_q <= 1'b0;
      tieCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      k_q         <= k_d;
      chalA_q     <= chalA_d;
      chalB_q     <= chalB_d;
      resp_q      <= resp_d;
      respValid_q <= respValid_d;
      tieCnt_q    <= tieCnt_d;
    end
  end

  // Next-state logic. Each timed state is entered with timer = dwell-1 and
  // leaves when the timer reaches zero. resp_valid is raised on the edge into
  // DONE so it is already high during the done pulse.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    k_d         = k_q;
    chalA_d     = chalA_q;
    chalB_d     = chalB_q;
    resp_d      = resp_q;
    respValid_d = respValid_q;
    tieCnt_d    = tieCnt_q;

    if (kill) begin
      state_d     = S_IDLE;
      timer_d     = '0;
      respValid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            chalA_d     = bus.chal_a;
            chalB_d     = bus.chal_b;
            resp_d      = '0;
            respValid_d = 1'b0;
            tieCnt_d    = '0;
            k_d         = '0;
            timer_d     = TW'(1);
            state_d     = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (timerZero) begin
            timer_d = TW'(WINDOW - 1);
            state_d = S_RUN;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_RUN: begin
          if (timerZero) begin
            timer_d = TW'(SETTLE - 1);
            state_d = S_SETTLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_SETTLE: begin
          if (timerZero) begin
            state_d = S_COMPARE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_COMPARE: begin
          resp_d = {resp_q[N_BITS-2:0], cmpGt};
          if (cmpEq) begin
            tieCnt_d = tieCnt_q + KW'(1);
          end
          k_d = k_q + KW'(1);
          if (k_q == KW'(N_BITS - 1)) begin
            respValid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            timer_d = TW'(1);
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from the state register; selects read zero
  // outside the evaluation states so idle/reset shows all-zero outputs.
  assign bus.ro_en      = (state_q == S_RUN);
  assign bus.cnt_clr    = (state_q == S_CLEAR);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.sel_a      = selActive ? (chalA_q + kSel) : '0;
  assign bus.sel_b      = selActive ? (chalB_q + kSel) : '0;
  assign bus.resp       = resp_q;
  assign bus.resp_valid = respValid_q;
  assign bus.tie_cnt    = tieCnt_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_eval_ctrl
// Self-checking bench for puf_eval_ctrl with a small datapath model: the
// counts presented to the sequencer are looked up from per-bit tables using
// the bit index implied by sel_a. Expected selects, run lengths and
// responses are queued when a challenge is started and popped when the
// sequencer produces them.
// ---------------------------------------------------------------------------
module tb_puf_eval_ctrl;

  localparam int WIN  = 8;
  localparam int SET  = 2;
  localparam int NB   = 4;
  localparam int CW   = 16;
  localparam int SW   = 5;
  localparam int TIEW = $clog2(NB + 1);
  localparam int EXP_DONE = NB * (WIN + SET + 3) + 1;

  typedef struct packed {
    logic [SW-1:0] a;
    logic [SW-1:0] b;
  } selPair_t;

  typedef struct packed {
    logic [NB-1:0]   resp;
    logic [TIEW-1:0] tie;
  } respExp_t;

  logic clk;
  logic rst_n;

  puf_eval_ctrl_if #(.SEL_W(SW), .CNT_W(CW), .N_BITS(NB)) bus ();

  puf_eval_ctrl #(
    .WINDOW(WIN), .SETTLE(SET), .N_BITS(NB), .CNT_W(CW), .SEL_W(SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int nVec = 0;
  int nErr = 0;

  selPair_t expSel[$];
  selPair_t obsSel[$];
  int       expRun[$];
  int       obsRun[$];
  respExp_t expResp[$];

  logic [SW-1:0] curChalA;
  logic [CW-1:0] tblA [NB];
  logic [CW-1:0] tblB [NB];
  logic [SW-1:0] modelIdx;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: bit index is recovered from sel_a relative to the base.
  always_comb begin
    modelIdx    = bus.sel_a - curChalA;
    bus.count_a = '0;
    bus.count_b = '0;
    if (modelIdx < SW'(NB)) begin
      bus.count_a = tblA[modelIdx[1:0]];
      bus.count_b = tblB[modelIdx[1:0]];
    end
  end

  // Reference response for the first nb evaluations of the current tables.
  function automatic respExp_t modelResult(input int nb);
    respExp_t r;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      r.resp = {r.resp[NB-2:0], (tblA[i] > tblB[i])};
      if (tblA[i] == tblB[i]) r.tie = r.tie + TIEW'(1);
    end
    return r;
  endfunction

  task automatic setBasicTables();
    for (int i = 0; i < NB; i++) tblA[i] = 16'd100;
    tblB[0] = 16'd90;
    tblB[1] = 16'd110;
    tblB[2] = 16'd100;
    tblB[3] = 16'd95;
  endtask

  task automatic pushSelExpect(input logic [SW-1:0] a, input logic [SW-1:0] b);
    selPair_t p;
    for (int k = 0; k < NB; k++) begin
      p.a = a + SW'(k);
      p.b = b + SW'(k);
      expSel.push_back(p);
      expRun.push_back(WIN);
    end
  endtask

  task automatic startChal(input logic [SW-1:0] a, input logic [SW-1:0] b);
    @(negedge clk);
    bus.chal_a = a;
    bus.chal_b = b;
    curChalA   = a;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Records sequencer activity for maxCycles cycles after the accept edge;
  // cycle 1 is the cycle right after the accept edge. If actCycle is
  // non-zero a one-cycle start pulse is driven in that cycle.
  task automatic collect(input int maxCycles, input int actCycle,
                         output int doneCycle, output int doneCount,
                         output logic [NB-1:0] respAtDone,
                         output logic [TIEW-1:0] tieAtDone,
                         output logic validAtDone);
    logic prevRo;
    logic prevClr;
    int   runLen;
    selPair_t p;
    prevRo = 1'b0;
    prevClr = 1'b0;
    runLen = 0;
    doneCycle = 0;
    doneCount = 0;
    respAtDone = '0;
    tieAtDone = '0;
    validAtDone = 1'b0;
    obsSel.delete();
    obsRun.delete();
    for (int cyc = 1; cyc <= maxCycles; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == actCycle);
      if (bus.cnt_clr && !prevClr) begin
        p.a = bus.sel_a;
        p.b = bus.sel_b;
        obsSel.push_back(p);
      end
      if (bus.ro_en) runLen++;
      else if (prevRo) begin
        obsRun.push_back(runLen);
        runLen = 0;
      end
      if (bus.done) begin
        if (doneCount == 0) begin
          doneCycle   = cyc;
          respAtDone  = bus.resp;
          tieAtDone   = bus.tie_cnt;
          validAtDone = bus.resp_valid;
        end
        doneCount++;
      end
      prevRo  = bus.ro_en;
      prevClr = bus.cnt_clr;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {bus.sel_a, bus.sel_b, bus.ro_en, bus.cnt_clr, bus.busy, bus.done,
           bus.resp, bus.resp_valid, bus.tie_cnt};
    nVec++;
    if (obs !== '0) begin
      nErr++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc, dn;
    logic [NB-1:0] r;
    logic [TIEW-1:0] t;
    logic v;
    respExp_t e;
    selPair_t es, os;
    int er, orun;
    setBasicTables();
    pushSelExpect(5'd3, 5'd9);
    expResp.push_back(modelResult(NB));
    startChal(5'd3, 5'd9);
    collect(60, 0, dc, dn, r, t, v);
    nVec++;
    if (dn !== 1) begin nErr++; $display("[TB] FAIL basic_done_count: got %0d expected 1", dn); end
    nVec++;
    if (dc !== EXP_DONE) begin nErr++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", dc, EXP_DONE); end
    while (expSel.size() > 0) begin
      es = expSel.pop_front();
      nVec++;
      if (obsSel.size() == 0) begin
        nErr++; $display("[TB] FAIL basic_sel: got none expected (%0d,%0d)", es.a, es.b);
      end else begin
        os = obsSel.pop_front();
        if (os !== es) begin
          nErr++; $display("[TB] FAIL basic_sel: got (%0d,%0d) expected (%0d,%0d)", os.a, os.b, es.a, es.b);
        end
      end
    end
    while (expRun.size() > 0) begin
      er = expRun.pop_front();
      nVec++;
      if (obsRun.size() == 0) begin
        nErr++; $display("[TB] FAIL basic_ro_len: got none expected %0d", er);
      end else begin
        orun = obsRun.pop_front();
        if (orun !== er) begin nErr++; $display("[TB] FAIL basic_ro_len: got %0d expected %0d", orun, er); end
      end
    end
    e = expResp.pop_front();
    nVec++;
    if (r !== e.resp) begin nErr++; $display("[TB] FAIL basic_resp: got %b expected %b", r, e.resp); end
    nVec++;
    if (t !== e.tie) begin nErr++; $display("[TB] FAIL basic_tie: got %0d expected %0d", t, e.tie); end
    nVec++;
    if (v !== 1'b1) begin nErr++; $display("[TB] FAIL basic_valid: got %b expected 1", v); end
    // After the challenge the response must be held while idle.
    nVec++;
    if ({bus.busy, bus.resp_valid, bus.resp} !== {1'b0, 1'b1, e.resp}) begin
      nErr++;
      $display("[TB] FAIL basic_hold: got busy=%b valid=%b resp=%b expected busy=0 valid=1 resp=%b",
               bus.busy, bus.resp_valid, bus.resp, e.resp);
    end
  endtask

  task automatic test_wrap();
    int dc, dn;
    logic [NB-1:0] r;
    logic [TIEW-1:0] t;
    logic v;
    respExp_t e;
    selPair_t es, os;
    tblA[0] = 16'h8000; tblB[0] = 16'h7FFF;
    tblA[1] = 16'h0001; tblB[1] = 16'h8000;
    tblA[2] = 16'hFFFF; tblB[2] = 16'hFFFF;
    tblA[3] = 16'h1234; tblB[3] = 16'h1235;
    pushSelExpect(5'd31, 5'd30);
    expRun.delete();
    expResp.push_back(modelResult(NB));
    startChal(5'd31, 5'd30);
    collect(60, 0, dc, dn, r, t, v);
    while (expSel.size() > 0) begin
      es = expSel.pop_front();
      nVec++;
      if (obsSel.size() == 0) begin
        nErr++; $display("[TB] FAIL wrap_sel: got none expected (%0d,%0d)", es.a, es.b);
      end else begin
        os = obsSel.pop_front();
        if (os !== es) begin
          nErr++; $display("[TB] FAIL wrap_sel: got (%0d,%0d) expected (%0d,%0d)", os.a, os.b, es.a, es.b);
        end
      end
    end
    e = expResp.pop_front();
    nVec++;
    if ({r, t} !== {e.resp, e.tie}) begin
      nErr++; $display("[TB] FAIL wrap_resp: got %b/%0d expected %b/%0d", r, t, e.resp, e.tie);
    end
  endtask

  task automatic test_abort();
    bit found;
    int doneSeen, busySeen;
    respExp_t e;
    setBasicTables();
    e = modelResult(2);
    startChal(5'd2, 5'd7);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.ro_en && bus.sel_a == 5'd4) found = 1;
    end
    nVec++;
    if (!found) begin nErr++; $display("[TB] FAIL abort_reach_run: got timeout expected RUN of bit 2"); end
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    nVec++;
    if ({bus.ro_en, bus.cnt_clr, bus.busy, bus.done, bus.resp_valid} !== 5'b0) begin
      nErr++;
      $display("[TB] FAIL abort_idle: got ro=%b clr=%b busy=%b done=%b valid=%b expected all 0",
               bus.ro_en, bus.cnt_clr, bus.busy, bus.done, bus.resp_valid);
    end
    nVec++;
    if ({bus.resp, bus.tie_cnt} !== {e.resp, e.tie}) begin
      nErr++; $display("[TB] FAIL abort_partial: got %b/%0d expected %b/%0d", bus.resp, bus.tie_cnt, e.resp, e.tie);
    end
    bus.abort = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
      if (bus.busy) busySeen++;
    end
    nVec++;
    if (doneSeen + busySeen != 0) begin
      nErr++; $display("[TB] FAIL abort_quiet: got done=%0d busy=%0d expected 0/0", doneSeen, busySeen);
    end
    // Dropping ena behaves like abort.
    startChal(5'd4, 5'd4);
    repeat (5) @(negedge clk);
    bus.ena = 1'b0;
    @(posedge clk);
    #1;
    nVec++;
    if ({bus.busy, bus.ro_en, bus.cnt_clr} !== 3'b0) begin
      nErr++; $display("[TB] FAIL ena_abort: got busy=%b ro=%b clr=%b expected 0", bus.busy, bus.ro_en, bus.cnt_clr);
    end
    @(negedge clk);
    bus.ena = 1'b1;
  endtask

  task automatic test_start_ignored();
    int dc, dn, doneSeen, busySeen;
    logic [NB-1:0] r;
    logic [TIEW-1:0] t;
    logic v;
    respExp_t e;
    setBasicTables();
    expResp.push_back(modelResult(NB));
    startChal(5'd10, 5'd20);
    collect(60, 20, dc, dn, r, t, v);
    e = expResp.pop_front();
    nVec++;
    if (dn !== 1 || dc !== EXP_DONE) begin
      nErr++; $display("[TB] FAIL busy_start_done: got count=%0d cycle=%0d expected 1/%0d", dn, dc, EXP_DONE);
    end
    nVec++;
    if (r !== e.resp) begin nErr++; $display("[TB] FAIL busy_start_resp: got %b expected %b", r, e.resp); end
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    nVec++;
    if (bus.busy !== 1'b0) begin nErr++; $display("[TB] FAIL start_abort_busy: got %b expected 0", bus.busy); end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
      if (bus.busy) busySeen++;
    end
    nVec++;
    if (doneSeen + busySeen != 0) begin
      nErr++; $display("[TB] FAIL start_abort_quiet: got done=%0d busy=%0d expected 0/0", doneSeen, busySeen);
    end
    nVec++;
    if (bus.resp !== e.resp) begin nErr++; $display("[TB] FAIL start_abort_resp: got %b expected %b", bus.resp, e.resp); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int dc, dn;
    logic [NB-1:0] r;
    logic [TIEW-1:0] t;
    logic v;
    logic [21:0] obs;
    respExp_t e;
    setBasicTables();
    startChal(5'd3, 5'd9);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.ro_en && bus.sel_a == 5'd4) found = 1;
    end
    nVec++;
    if (!found) begin nErr++; $display("[TB] FAIL rst_reach_run: got timeout expected RUN of bit 1"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {bus.sel_a, bus.sel_b, bus.ro_en, bus.cnt_clr, bus.busy, bus.done,
           bus.resp, bus.resp_valid, bus.tie_cnt};
    nVec++;
    if (obs !== '0) begin nErr++; $display("[TB] FAIL rst_async: got %h expected 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    expResp.push_back(modelResult(NB));
    startChal(5'd3, 5'd9);
    collect(60, 0, dc, dn, r, t, v);
    e = expResp.pop_front();
    nVec++;
    if (dn !== 1 || dc !== EXP_DONE) begin
      nErr++; $display("[TB] FAIL rst_rerun_done: got count=%0d cycle=%0d expected 1/%0d", dn, dc, EXP_DONE);
    end
    nVec++;
    if ({r, t, v} !== {e.resp, e.tie, 1'b1}) begin
      nErr++; $display("[TB] FAIL rst_rerun_resp: got %b/%0d/%b expected %b/%0d/1", r, t, v, e.resp, e.tie);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.chal_a  = '0;
    bus.chal_b  = '0;
    curChalA    = '0;
    for (int i = 0; i < NB; i++) begin
      tblA[i] = '0;
      tblB[i] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
